// File: rtl/muldiv_arbiter_pkg.sv
// Shared definitions for the two-requester multiply/divide scaling arbiter.
package muldiv_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic int sat_max_default(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/muldiv_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves past the winner on accept.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  // The pointer's requester wins unless it is idle.
  always_comb begin
    gnt_idx_o = ptr_q;
    if (!req_i[ptr_q]) gnt_idx_o = ~ptr_q;
  end

  assign ptr_d = accept_i ? ~gnt_idx_o : ptr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one multiplier and one divider between two requesters computing
// (A*B)/D + OUT_OFFSET, saturated, with round-robin arbitration.
module muldiv_arbiter
  import muldiv_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_OFFSET = 0,
  parameter int SAT_MAX    = sat_max_default(DATA_WIDTH)
) (
  input  logic                    clk_i_arb,
  input  logic                    rstn_i_arb,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [2*DATA_WIDTH-1:0] a_i,
  input  logic [2*DATA_WIDTH-1:0] b_i,
  input  logic [2*DATA_WIDTH-1:0] d_i,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    en_o_mult,
  output logic [DATA_WIDTH-1:0]   mult_a_o,
  output logic [DATA_WIDTH-1:0]   mult_b_o,
  input  logic [2*DATA_WIDTH-1:0] result_i_mult,
  input  logic                    mult_done_i,
  output logic                    en_o_div,
  output logic [2*DATA_WIDTH-1:0] div_q_o,
  output logic [DATA_WIDTH-1:0]   div_b_o,
  input  logic [DATA_WIDTH-1:0]   result_i_div,
  input  logic                    div_done_i
);

  localparam logic [DATA_WIDTH-1:0] SAT_V = SAT_MAX[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH:0]   OFF_V = OUT_OFFSET[DATA_WIDTH:0];

  state_e st_q, st_d;

  logic [DATA_WIDTH-1:0]   a_q, b_q, d_q, res_q, result_q;
  logic [2*DATA_WIDTH-1:0] prod_q;
  logic                    gnt_q, err_pend_q, err_q;
  logic [NUM_REQ-1:0]      done_q;

  logic                  gidx, accept;
  logic [DATA_WIDTH-1:0] a_sel, b_sel, d_sel, res_sat;
  logic [DATA_WIDTH:0]   sum;

  assign accept = (st_q == IDLE) && (|req_i);

  rr_arbiter2 u_rr (
    .clk_i     (clk_i_arb),
    .rstn_i    (rstn_i_arb),
    .req_i     (req_i),
    .accept_i  (accept),
    .gnt_idx_o (gidx)
  );

  assign a_sel = gidx ? a_i[2*DATA_WIDTH-1:DATA_WIDTH] : a_i[DATA_WIDTH-1:0];
  assign b_sel = gidx ? b_i[2*DATA_WIDTH-1:DATA_WIDTH] : b_i[DATA_WIDTH-1:0];
  assign d_sel = gidx ? d_i[2*DATA_WIDTH-1:DATA_WIDTH] : d_i[DATA_WIDTH-1:0];

  // One spare bit so the offset add cannot wrap before the ceiling compare.
  assign sum     = {1'b0, result_i_div} + OFF_V;
  assign res_sat = (sum > {1'b0, SAT_V}) ? SAT_V : sum[DATA_WIDTH-1:0];

  always_ff @(posedge clk_i_arb or negedge rstn_i_arb) begin
    if (!rstn_i_arb) st_q <= IDLE;
    else             st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (|req_i) st_d = (d_sel == '0) ? RESP : MULT;
      MULT:    if (mult_done_i) st_d = DIV;
      DIV:     if (div_done_i) st_d = RESP;
      RESP:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    en_o_mult = (st_q == MULT);
    en_o_div  = (st_q == DIV);
    busy_o    = (st_q != IDLE);
  end

  always_ff @(posedge clk_i_arb or negedge rstn_i_arb) begin
    if (!rstn_i_arb) begin
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      res_q      <= '0;
      result_q   <= '0;
      prod_q     <= '0;
      gnt_q      <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (st_q)
        IDLE: if (|req_i) begin
          gnt_q      <= gidx;
          a_q        <= a_sel;
          b_q        <= b_sel;
          d_q        <= d_sel;
          res_q      <= SAT_V;
          err_pend_q <= (d_sel == '0);
        end
        MULT: if (mult_done_i) prod_q <= result_i_mult;
        DIV:  if (div_done_i) res_q <= res_sat;
        RESP: begin
          result_q      <= res_q;
          err_q         <= err_pend_q;
          done_q[gnt_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;
  assign err_o    = err_q;
  assign mult_a_o = a_q;
  assign mult_b_o = b_q;
  assign div_q_o  = prod_q;
  assign div_b_o  = d_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Randomised and directed bench for muldiv_arbiter with behavioural engines
// and a transaction-level reference model.
module tb_muldiv_arbiter;

  localparam int DW   = 8;
  localparam int OFF  = 10;
  localparam int SATV = 255;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [1:0]      req;
  logic [2*DW-1:0] a, b, d;
  logic [1:0]      done_o;
  logic [DW-1:0]   result_o;
  logic            err_o, busy_o, en_o_mult, en_o_div;
  logic [DW-1:0]   mult_a_o, mult_b_o, div_b_o, result_i_div;
  logic [2*DW-1:0] div_q_o, result_i_mult;
  logic            mult_done_i, div_done_i;

  always #5 clk = ~clk;

  muldiv_arbiter #(.DATA_WIDTH(DW), .OUT_OFFSET(OFF), .SAT_MAX(SATV)) dut (
    .clk_i_arb(clk), .rstn_i_arb(rstn), .req_i(req), .a_i(a), .b_i(b), .d_i(d),
    .done_o(done_o), .result_o(result_o), .err_o(err_o), .busy_o(busy_o),
    .en_o_mult(en_o_mult), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .result_i_mult(result_i_mult), .mult_done_i(mult_done_i),
    .en_o_div(en_o_div), .div_q_o(div_q_o), .div_b_o(div_b_o),
    .result_i_div(result_i_div), .div_done_i(div_done_i)
  );

  typedef struct { int a; int b; int d; bit wd; } job_t;
  typedef struct { int idx; int res; int err; int cyc; } dn_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  job_t jq[2][$];
  dn_t  dlog[$];
  int   ast[2];
  int   pres_cyc[2];
  bit   rand_en = 0;

  // reference model: one outstanding transaction at a time
  bit m_idle, m_pend;
  int m_ptr, m_idx, m_a, m_b, m_d, m_res, m_err, m_exp, m_gcyc, rise_m, rise_d, res_hold;
  // engine models
  int mcnt, dcnt;
  bit pm, pd, mhand, dhand;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_slice(input int i, input int va, input int vb, input int vd);
    a[i*DW +: DW] = DW'(va);
    b[i*DW +: DW] = DW'(vb);
    d[i*DW +: DW] = DW'(vd);
  endtask

  function automatic job_t rand_job();
    job_t j;
    int p, lo;
    j.a = $urandom_range(0, 255);
    j.b = $urandom_range(0, 255);
    p = j.a * j.b;
    lo = (p == 0) ? 1 : (p + 254) / 255;   // keeps the quotient within DW bits
    j.d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(lo, 255);
    j.wd = ($urandom_range(0, 4) == 0);
    return j;
  endfunction

  function automatic job_t mk(input int va, input int vb, input int vd, input bit w);
    job_t j;
    j.a = va; j.b = vb; j.d = vd; j.wd = w;
    return j;
  endfunction

  task automatic step();
    bit exp_busy;
    logic [1:0] dn;
    @(negedge clk);
    cyc++;
    dn = done_o;
    // ---- checks on what the DUT shows this cycle
    exp_busy = m_pend && (cyc != m_exp);
    chk("busy", int'(busy_o), int'(exp_busy));
    if (en_o_mult && en_o_div) chk("en_exclusive", 1, 0);
    if (mhand) begin
      chk("mult_en_drop", int'(en_o_mult), 0);
      chk("div_en_start", int'(en_o_div), 1);
    end else if (pm) chk("mult_en_hold", int'(en_o_mult), 1);
    if (dhand) chk("div_en_drop", int'(en_o_div), 0);
    else if (pd) chk("div_en_hold", int'(en_o_div), 1);
    if (m_pend && cyc == m_gcyc + 1) chk("mult_en_after_grant", int'(en_o_mult), int'(m_d != 0));
    if (en_o_mult) begin
      if (!pm) rise_m++;
      if (int'(mult_a_o) != m_a || int'(mult_b_o) != m_b) chk("mult_operands", int'(mult_a_o), m_a);
    end
    if (en_o_div) begin
      if (!pd) rise_d++;
      if (int'(div_q_o) != m_a * m_b || int'(div_b_o) != m_d) chk("div_operands", int'(div_q_o), m_a * m_b);
    end
    if (dn != 2'b00) begin
      if (!m_pend) chk("spurious_done", int'(dn), 0);
      else begin
        chk("done_idx", int'(dn), 1 << m_idx);
        chk("done_time", cyc, m_exp);
        chk("result", int'(result_o), m_res);
        chk("err", int'(err_o), m_err);
        chk("mult_windows", rise_m, int'(m_d != 0));
        chk("div_windows", rise_d, int'(m_d != 0));
        dlog.push_back('{m_idx, int'(result_o), int'(err_o), cyc});
        m_pend = 0;
        m_idle = 1;
      end
      res_hold = int'(result_o);
    end else begin
      if (err_o) chk("err_without_done", 1, 0);
      if (int'(result_o) != res_hold) chk("result_hold", int'(result_o), res_hold);
      if (m_pend && cyc == m_exp) chk("done_missing", 0, 1);
      if (m_pend && cyc - m_gcyc > 60) begin
        chk("done_timeout", 0, 1);
        m_pend = 0; m_idle = 1;
      end
    end
    pm = en_o_mult;
    pd = en_o_div;
    // ---- engines
    mhand = 0;
    if (mult_done_i) mult_done_i = 1'b0;
    else if (en_o_mult) begin
      if (mcnt == 0) begin
        mult_done_i = 1'b1;
        result_i_mult = 16'(mult_a_o) * 16'(mult_b_o);
        mcnt = $urandom_range(0, 3);
        mhand = 1;
      end else mcnt--;
    end else if ($urandom_range(0, 9) == 0) begin
      mult_done_i = 1'b1;
      result_i_mult = 16'($urandom);
    end
    dhand = 0;
    if (div_done_i) div_done_i = 1'b0;
    else if (en_o_div) begin
      if (dcnt == 0) begin
        div_done_i = 1'b1;
        result_i_div = (div_b_o != 0) ? 8'(div_q_o / 16'(div_b_o)) : 8'hFF;
        dcnt = $urandom_range(0, 3);
        dhand = 1;
        if (m_pend) m_exp = cyc + 2;
      end else dcnt--;
    end else if ($urandom_range(0, 9) == 0) begin
      div_done_i = 1'b1;
      result_i_div = 8'($urandom);
    end
    // ---- requesters
    for (int i = 0; i < 2; i++) begin
      if (dn[i]) begin
        if (jq[i].size() > 0) void'(jq[i].pop_front());
        ast[i] = 0;
        req[i] = 1'b0;
      end
      if (ast[i] == 0) begin
        if (jq[i].size() == 0 && rand_en && $urandom_range(0, 2) == 0) jq[i].push_back(rand_job());
        if (jq[i].size() > 0) begin
          set_slice(i, jq[i][0].a, jq[i][0].b, jq[i][0].d);
          req[i] = 1'b1;
          ast[i] = 1;
          pres_cyc[i] = cyc;
        end else set_slice(i, $urandom, $urandom, $urandom);
      end else if (ast[i] == 1 && m_pend && m_idx == i && cyc > m_gcyc && jq[i][0].wd) begin
        req[i] = 1'b0;
        ast[i] = 2;
        set_slice(i, $urandom, $urandom, $urandom);
      end else if (ast[i] == 2) set_slice(i, $urandom, $urandom, $urandom);
    end
    // ---- model: grant decision on what the DUT samples at the next edge
    if (m_idle && req != 2'b00) begin
      int w, q, s;
      w = req[m_ptr] ? m_ptr : 1 - m_ptr;
      m_ptr = 1 - w;
      m_idle = 0; m_pend = 1; m_idx = w; m_gcyc = cyc;
      m_a = int'(a[w*DW +: DW]); m_b = int'(b[w*DW +: DW]); m_d = int'(d[w*DW +: DW]);
      rise_m = 0; rise_d = 0;
      if (m_d == 0) begin
        m_res = SATV; m_err = 1; m_exp = cyc + 2;
      end else begin
        q = (m_a * m_b) / m_d;
        s = q + OFF;
        m_res = (s > SATV) ? SATV : s;
        m_err = 0; m_exp = -1;
      end
    end
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_en_mult", int'(en_o_mult), 0);
    chk("rst_en_div", int'(en_o_div), 0);
    chk("rst_mult_ops", int'({mult_a_o, mult_b_o}), 0);
    chk("rst_div_ops", int'({div_q_o, div_b_o}), 0);
    req = '0; a = '0; b = '0; d = '0;
    mult_done_i = 1'b0; div_done_i = 1'b0; result_i_mult = '0; result_i_div = '0;
    m_idle = 1; m_pend = 0; m_ptr = 0; m_exp = -1; res_hold = 0;
    pm = 0; pd = 0; mhand = 0; dhand = 0; mcnt = 0; dcnt = 0;
    for (int i = 0; i < 2; i++) begin ast[i] = 0; jq[i].delete(); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_pend || jq[0].size() > 0 || jq[1].size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  task automatic expect_log(input int k, input string nm, input int idx, input int res, input int err);
    if (dlog.size() <= k) chk({nm, "_missing"}, dlog.size(), k + 1);
    else begin
      chk({nm, "_idx"}, dlog[k].idx, idx);
      chk({nm, "_res"}, dlog[k].res, res);
      chk({nm, "_err"}, dlog[k].err, err);
    end
  endtask

  initial begin
    int n;
    do_reset();

    // single request: 100*255/200 = 127, +10
    dlog.delete();
    jq[0].push_back(mk(100, 255, 200, 0));
    drain(200);
    expect_log(0, "single", 0, 137, 0);
    chk("single_count", dlog.size(), 1);

    // simultaneous from reset, both keep requesting -> 0,1,0,1
    do_reset();
    dlog.delete();
    for (int k = 0; k < 2; k++) begin
      jq[0].push_back(mk(50, 255, 100, 0));
      jq[1].push_back(mk(10, 20, 4, 0));
    end
    drain(400);
    expect_log(0, "alt0", 0, 137, 0);
    expect_log(1, "alt1", 1, 60, 0);
    expect_log(2, "alt2", 0, 137, 0);
    expect_log(3, "alt3", 1, 60, 0);

    // divide by zero on requester 1: done two cycles after req
    dlog.delete();
    jq[1].push_back(mk(7, 9, 0, 0));
    drain(100);
    expect_log(0, "dz", 1, 255, 1);
    if (dlog.size() > 0) chk("dz_latency", dlog[0].cyc - pres_cyc[1], 2);

    // saturation: quotient 255 + 10 clips to 255
    dlog.delete();
    jq[0].push_back(mk(255, 255, 255, 0));
    drain(100);
    expect_log(0, "sat", 0, 255, 0);

    // withdrawal after grant with operands scrambled: 20000/250 = 80, +10
    dlog.delete();
    jq[0].push_back(mk(200, 100, 250, 1));
    drain(100);
    expect_log(0, "withdraw", 0, 90, 0);

    // reset during DIV, then pointer must be back on requester 0
    dlog.delete();
    jq[0].push_back(mk(40, 50, 10, 0));
    n = 0;
    while (!en_o_div && n < 50) begin step(); n++; end
    chk("reach_div", int'(en_o_div), 1);
    do_reset();
    for (int k = 0; k < 3; k++) step();
    chk("no_done_after_reset", dlog.size(), 0);
    jq[1].push_back(mk(10, 20, 4, 0));
    jq[0].push_back(mk(30, 40, 12, 0));
    drain(200);
    expect_log(0, "post_rst0", 0, 110, 0);
    expect_log(1, "post_rst1", 1, 60, 0);

    // random traffic checked against the model every cycle
    rand_en = 1;
    for (int k = 0; k < 4000; k++) step();
    rand_en = 0;
    drain(400);
    chk("random_traffic_seen", int'(dlog.size() > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
